// File: rtl/stream_xbar_arb.sv
// Per-output packet arbiter for a stream crossbar: round-robin grant per port,
// locked for a whole packet, with source ready derived from the live grants.
module stream_xbar_arb #(
  parameter int S_DATA_COUNT   = 2,
  parameter int M_DATA_COUNT   = 3,
  localparam int T_DEST_WIDTH  = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [S_DATA_COUNT-1:0]                s_valid_i,
  input  logic [S_DATA_COUNT-1:0]                s_last_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0]   s_dest_i,
  input  logic [M_DATA_COUNT-1:0]                m_ready_i,
  output logic [M_DATA_COUNT*S_DATA_COUNT-1:0]   req_o,
  output logic [S_DATA_COUNT-1:0]                s_ready_o,
  output logic [S_DATA_COUNT-1:0]                dest_err_o
);

  localparam int OW = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q [M_DATA_COUNT];
  state_t                  state_d [M_DATA_COUNT];
  logic [OW-1:0]           owner_q [M_DATA_COUNT];
  logic [OW-1:0]           owner_d [M_DATA_COUNT];
  logic [OW-1:0]           ptr_q   [M_DATA_COUNT];
  logic [OW-1:0]           ptr_d   [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] cand    [M_DATA_COUNT];
  logic [T_DEST_WIDTH-1:0] dest    [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] owned;
  logic [S_DATA_COUNT-1:0] bad_dest;
  logic [S_DATA_COUNT-1:0] dest_err_q;

  // Candidate sets: a source already holding some port is excluded everywhere.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    owned    = '0;
    bad_dest = '0;
    for (int s = 0; s < S_DATA_COUNT; s++) begin
      dest[s]     = s_dest_i[s*T_DEST_WIDTH +: T_DEST_WIDTH];
      bad_dest[s] = s_valid_i[s] && (int'(dest[s]) >= M_DATA_COUNT);
    end
    for (int p = 0; p < M_DATA_COUNT; p++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        if (state_q[p] == BUSY && owner_q[p] == OW'(s)) owned[s] = 1'b1;
      end
    end
    for (int p = 0; p < M_DATA_COUNT; p++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        cand[p][s] = s_valid_i[s] && (dest[s] == T_DEST_WIDTH'(p)) && !owned[s];
      end
    end
  end

  // Next-state: IDLE picks the first candidate at or after the pointer.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    for (int p = 0; p < M_DATA_COUNT; p++) begin
      state_d[p] = state_q[p];
      owner_d[p] = owner_q[p];
      ptr_d[p]   = ptr_q[p];
      found      = 1'b0;
      case (state_q[p])
        IDLE: begin
          for (int i = 0; i < S_DATA_COUNT; i++) begin
            idx = (int'(ptr_q[p]) + i) % S_DATA_COUNT;
            if (!found && cand[p][idx]) begin
              found      = 1'b1;
              owner_d[p] = OW'(idx);
            end
          end
          if (found) state_d[p] = BUSY;
        end
        BUSY: begin
          // Only a completed handshake of the last beat releases the port.
          if (s_valid_i[owner_q[p]] && m_ready_i[p] && s_last_i[owner_q[p]]) begin
            state_d[p] = IDLE;
            ptr_d[p]   = OW'((int'(owner_q[p]) + 1) % S_DATA_COUNT);
          end
        end
        default: state_d[p] = IDLE;
      endcase
    end
  end

  // Outputs come only from registered grants plus slave ready.
  always_comb begin
    req_o     = '0;
    s_ready_o = '0;
    for (int p = 0; p < M_DATA_COUNT; p++) begin
      if (state_q[p] == BUSY) begin
        req_o[p*S_DATA_COUNT + int'(owner_q[p])] = 1'b1;
        s_ready_o[owner_q[p]] = s_ready_o[owner_q[p]] | m_ready_i[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: owner/pointer arrays are reset too: pointers must restart at 0 for fairness order.
      for (int p = 0; p < M_DATA_COUNT; p++) begin
        state_q[p] <= IDLE;
        owner_q[p] <= '0;
        ptr_q[p]   <= '0;
      end
      dest_err_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      for (int p = 0; p < M_DATA_COUNT; p++) begin
        state_q[p] <= state_d[p];
        owner_q[p] <= owner_d[p];
        ptr_q[p]   <= ptr_d[p];
      end
      dest_err_q <= dest_err_q | bad_dest;
    end
  end

  assign dest_err_o = dest_err_q;

endmodule

// File: tb/tb_stream_xbar_arb.sv
// Directed bench for stream_xbar_arb: a vector table of per-cycle inputs and
// expected outputs, followed by hand-written reset and backpressure sequences.
module tb_stream_xbar_arb;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] s_valid_i;
  logic [1:0] s_last_i;
  logic [3:0] s_dest_i;    // {dest1, dest0}
  logic [2:0] m_ready_i;
  logic [5:0] req_o;       // {port2, port1, port0}, 2 bits each
  logic [1:0] s_ready_o;
  logic [1:0] dest_err_o;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       rst;
    logic [1:0] valid;
    logic [1:0] last;
    logic [3:0] dest;
    logic [2:0] mready;
    logic [5:0] exp_req;
    logic [1:0] exp_rdy;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[$];

  stream_xbar_arb dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_valid_i  (s_valid_i),
    .s_last_i   (s_last_i),
    .s_dest_i   (s_dest_i),
    .m_ready_i  (m_ready_i),
    .req_o      (req_o),
    .s_ready_o  (s_ready_o),
    .dest_err_o (dest_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic [1:0] valid, input logic [1:0] last,
                     input logic [3:0] dest, input logic [2:0] mready,
                     input logic [5:0] exp_req, input logic [1:0] exp_rdy,
                     input logic [1:0] exp_err);
    vec_t v;
    v = '{rst, valid, last, dest, mready, exp_req, exp_rdy, exp_err};
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, compare mid-low-phase, then let the rising edge commit.
  task automatic step(input string name, input vec_t v);
    @(negedge clk_i);
    rst_i     = v.rst;
    s_valid_i = v.valid;
    s_last_i  = v.last;
    s_dest_i  = v.dest;
    m_ready_i = v.mready;
    #2;
    check({name, " req"},   {2'b00, req_o},      {2'b00, v.exp_req});
    check({name, " ready"}, {6'b0, s_ready_o},   {6'b0, v.exp_rdy});
    check({name, " err"},   {6'b0, dest_err_o},  {6'b0, v.exp_err});
    @(posedge clk_i);
  endtask

  initial begin
    // rst  valid  last   dest     mready  exp_req     rdy    err
    // Single source to port 2, three beats
    add(1, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 4'b0010, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 4'b0010, 3'b111, 6'b010000, 2'b01, 2'b00);
    add(0, 2'b01, 2'b00, 4'b0010, 3'b111, 6'b010000, 2'b01, 2'b00);
    add(0, 2'b01, 2'b01, 4'b0010, 3'b111, 6'b010000, 2'b01, 2'b00);
    add(0, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    // Contention on port 0, 2-beat packets: order 0,1,0,1 with idle gaps
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000001, 2'b01, 2'b00);
    add(0, 2'b11, 2'b01, 4'b0000, 3'b111, 6'b000001, 2'b01, 2'b00);
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000010, 2'b10, 2'b00);
    add(0, 2'b11, 2'b10, 4'b0000, 3'b111, 6'b000010, 2'b10, 2'b00);
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000001, 2'b01, 2'b00);
    add(0, 2'b11, 2'b01, 4'b0000, 3'b111, 6'b000001, 2'b01, 2'b00);
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 4'b0000, 3'b111, 6'b000010, 2'b10, 2'b00);
    add(0, 2'b11, 2'b10, 4'b0000, 3'b111, 6'b000010, 2'b10, 2'b00);
    add(0, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    // Parallel ports: source 0 -> port 0, source 1 -> port 2
    add(0, 2'b11, 2'b00, 4'b1000, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 4'b1000, 3'b111, 6'b100001, 2'b11, 2'b00);
    add(0, 2'b11, 2'b00, 4'b1000, 3'b001, 6'b100001, 2'b01, 2'b00);
    add(0, 2'b11, 2'b00, 4'b1000, 3'b100, 6'b100001, 2'b10, 2'b00);
    add(0, 2'b11, 2'b11, 4'b1000, 3'b101, 6'b100001, 2'b11, 2'b00);
    add(0, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);
    // Bad dest on source 1: sticky error, never granted; single-beat packet on port 1
    add(0, 2'b10, 2'b00, 4'b1100, 3'b111, 6'b000000, 2'b00, 2'b00);
    add(0, 2'b10, 2'b00, 4'b1100, 3'b111, 6'b000000, 2'b00, 2'b10);
    add(0, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b10);
    add(0, 2'b01, 2'b01, 4'b0001, 3'b111, 6'b000000, 2'b00, 2'b10);
    add(0, 2'b01, 2'b01, 4'b0001, 3'b111, 6'b000100, 2'b01, 2'b10);
    add(0, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b10);
    add(1, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b10);
    add(0, 2'b00, 2'b00, 4'b0000, 3'b111, 6'b000000, 2'b00, 2'b00);

    rst_i     = 1'b1;
    s_valid_i = '0;
    s_last_i  = '0;
    s_dest_i  = '0;
    m_ready_i = '0;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < vecs.size(); i++) step($sformatf("v%0d", i), vecs[i]);

    // Reset mid-packet: port 1 busy with owner 0, then source 1 alone wins after reset
    step("rst_a", '{0, 2'b01, 2'b00, 4'b0001, 3'b111, 6'b000000, 2'b00, 2'b00});
    step("rst_b", '{0, 2'b01, 2'b00, 4'b0001, 3'b111, 6'b000100, 2'b01, 2'b00});
    step("rst_c", '{1, 2'b01, 2'b00, 4'b0001, 3'b111, 6'b000100, 2'b01, 2'b00});
    step("rst_d", '{0, 2'b10, 2'b00, 4'b0100, 3'b111, 6'b000000, 2'b00, 2'b00});
    step("rst_e", '{0, 2'b10, 2'b00, 4'b0100, 3'b111, 6'b001000, 2'b10, 2'b00});
    step("rst_f", '{0, 2'b10, 2'b10, 4'b0100, 3'b111, 6'b001000, 2'b10, 2'b00});

    // Backpressure: owner 1 on port 1 holds through 4 stalled cycles while source 0 waits
    step("bp_grant", '{0, 2'b10, 2'b00, 4'b0100, 3'b111, 6'b000000, 2'b00, 2'b00});
    for (int i = 0; i < 4; i++)
      step($sformatf("bp_stall%0d", i), '{0, 2'b11, 2'b00, 4'b0101, 3'b101, 6'b001000, 2'b00, 2'b00});
    step("bp_last",  '{0, 2'b11, 2'b10, 4'b0101, 3'b111, 6'b001000, 2'b10, 2'b00});
    step("bp_idle",  '{0, 2'b01, 2'b00, 4'b0001, 3'b111, 6'b000000, 2'b00, 2'b00});
    step("bp_next",  '{0, 2'b01, 2'b00, 4'b0001, 3'b111, 6'b000100, 2'b01, 2'b00});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
